// File: rtl/calc_pkg.sv
// Shared constants and types for the calculator display receiver.
package calc_pkg;

    typedef logic [3:0] digit_t;

    localparam int NDIG = 8;

    localparam logic [1:0] ST_ERRO    = 2'b00;
    localparam logic [1:0] ST_OCUPADO = 2'b01;
    localparam logic [1:0] ST_PRONTO  = 2'b10;

    // Active-low, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_R     = 7'b0101111;
    localparam logic [6:0] SEG_O     = 7'b0100011;

endpackage

// File: rtl/seg7_decode.sv
// BCD to active-low seven-segment glyph; values above 9 render as a dash.
module seg7_decode
    import calc_pkg::*;
(
    input  digit_t     digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (digit)
            4'd0: seg = 7'b1000000;
            4'd1: seg = 7'b1111001;
            4'd2: seg = 7'b0100100;
            4'd3: seg = 7'b0110000;
            4'd4: seg = 7'b0011001;
            4'd5: seg = 7'b0010010;
            4'd6: seg = 7'b0000010;
            4'd7: seg = 7'b1111000;
            4'd8: seg = 7'b0000000;
            4'd9: seg = 7'b0010000;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/calc_display.sv
// Captures the calculator print stream into a shadow frame, commits it on
// busy->ready, and scans the committed frame onto an 8-digit display.
module calc_display
    import calc_pkg::*;
#(
    parameter int SCAN_DIV      = 50000,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] status,
    input  logic [3:0] data,
    input  logic [3:0] pos,
    output logic [7:0] an,
    output logic [6:0] seg,
    output logic       frame_valid,
    output logic       err
);

    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    digit_t        shadow [NDIG];
    digit_t        frame  [NDIG];
    logic [1:0]    status_q;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic [2:0]    idx;
    logic [2:0]    idx_next;
    logic          wrap;
    logic          capture;
    logic          commit;
    logic [NDIG-1:0] lead;
    digit_t        cur;
    logic [6:0]    glyph;
    logic [6:0]    seg_next;
    logic [7:0]    an_next;

    seg7_decode u_dec (
        .digit (cur),
        .seg   (glyph)
    );

    always_comb begin
        wrap     = (cnt == CW'(SCAN_DIV - 1));
        cnt_next = wrap ? '0 : cnt + 1'b1;
        idx_next = idx + {2'b00, wrap};
        an_next  = ~(8'b1 << idx_next);
        capture  = (status == ST_OCUPADO) && !pos[3];
        commit   = (status_q == ST_OCUPADO) && (status == ST_PRONTO) && !err;
    end

    // lead[i] is set when digit i and every digit above it are zero.
    always_comb begin
        lead = '0;
        lead[NDIG-1] = (frame[NDIG-1] == 4'd0);
        for (int i = NDIG - 2; i >= 0; i--) begin
            lead[i] = lead[i+1] && (frame[i] == 4'd0);
        end
    end

    // Segments are computed for the slot being entered so an and seg switch together.
    always_comb begin
        cur      = frame[idx_next];
        seg_next = SEG_BLANK;
        if (err) begin
            case (idx_next)
                3'd3:    seg_next = SEG_E;
                3'd2:    seg_next = SEG_R;
                3'd1:    seg_next = SEG_R;
                3'd0:    seg_next = SEG_O;
                default: seg_next = SEG_BLANK;
            endcase
        end else if (!frame_valid) begin
            seg_next = SEG_BLANK;
        end else if (BLANK_LEADING && idx_next != 3'd0 && lead[idx_next]) begin
            seg_next = SEG_BLANK;
        end else begin
            seg_next = glyph;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < NDIG; i++) begin
                shadow[i] <= '0;
                frame[i]  <= '0;
            end
            status_q    <= ST_ERRO;
            frame_valid <= 1'b0;
            err         <= 1'b0;
            cnt         <= '0;
            idx         <= '0;
            an          <= 8'b1111_1110;
            seg         <= SEG_BLANK;
        end else begin
            if (capture) begin
                shadow[pos[2:0]] <= data;
            end
            if (commit) begin
                for (int i = 0; i < NDIG; i++) begin
                    frame[i] <= shadow[i];
                end
                frame_valid <= 1'b1;
            end
            if (status == ST_ERRO) begin
                err <= 1'b1;
            end
            status_q <= status;
            cnt      <= cnt_next;
            idx      <= idx_next;
            an       <= an_next;
            seg      <= seg_next;
        end
    end

endmodule

// File: tb/tb_calc_display.sv
// Self-checking bench for calc_display: vector table, directed corner cases, random stream.
module tb_calc_display;

    localparam int SD = 4;
    localparam logic [6:0] B  = 7'b1111111;
    localparam logic [6:0] DS = 7'b0111111;

    logic       clock;
    logic       reset;
    logic [1:0] status;
    logic [3:0] data;
    logic [3:0] pos;
    logic [7:0] an;
    logic [6:0] seg;
    logic       frame_valid;
    logic       err;

    calc_display #(.SCAN_DIV(SD), .BLANK_LEADING(1'b1)) dut (
        .clock       (clock),
        .reset       (reset),
        .status      (status),
        .data        (data),
        .pos         (pos),
        .an          (an),
        .seg         (seg),
        .frame_valid (frame_valid),
        .err         (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    logic [6:0] gl [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                            7'b0000000, 7'b0010000};

    // Reference state, updated once per clock from the inputs applied.
    int         m_t;
    int         m_idx;
    logic [3:0] m_sh [8];
    logic [3:0] m_fr [8];
    bit         m_fv;
    bit         m_err;
    logic [1:0] m_sq;
    logic [7:0] e_an;
    logic [6:0] e_seg;

    typedef struct {
        logic [31:0] digits;
        logic [55:0] segs;
    } vec_t;

    vec_t tbl [5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] exp_glyph(input int i);
        int msd;
        if (m_err) begin
            case (i)
                3: return 7'b0000110;
                2: return 7'b0101111;
                1: return 7'b0101111;
                0: return 7'b0100011;
                default: return B;
            endcase
        end
        if (!m_fv) return B;
        if (m_fr[i] > 9) return DS;
        msd = 0;
        for (int j = 0; j < 8; j++) if (m_fr[j] != 0) msd = j;
        if (i > msd) return B;
        return gl[m_fr[i]];
    endfunction

    task automatic step(input logic r, input logic [1:0] s,
                        input logic [3:0] d, input logic [3:0] p);
        reset = r; status = s; data = d; pos = p;
        @(posedge clock);
        if (!r) begin
            for (int i = 0; i < 8; i++) begin m_sh[i] = 0; m_fr[i] = 0; end
            m_fv = 0; m_err = 0; m_sq = 2'b00; m_t = 0; m_idx = 0;
            e_an = 8'hFE; e_seg = B;
        end else begin
            m_t++;
            m_idx = (m_t / SD) % 8;
            e_an  = ~(8'd1 << m_idx);
            e_seg = exp_glyph(m_idx);
            if (m_sq == 2'b01 && s == 2'b10 && !m_err) begin
                for (int i = 0; i < 8; i++) m_fr[i] = m_sh[i];
                m_fv = 1;
            end
            if (s == 2'b01 && p < 8) m_sh[p] = d;
            if (s == 2'b00) m_err = 1;
            m_sq = s;
        end
        #1;
        chk("an", 64'(an), 64'(e_an));
        chk("seg", 64'(seg), 64'(e_seg));
        chk("frame_valid", 64'(frame_valid), 64'(m_fv));
        chk("err", 64'(err), 64'(m_err));
    endtask

    task automatic do_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 2'b10, 4'd0, 4'd0);
    endtask

    task automatic load(input logic [31:0] digits);
        for (int i = 0; i < 8; i++) step(1'b1, 2'b01, digits[4*i +: 4], 4'(i));
    endtask

    task automatic scan_check(input string name, input logic [55:0] segs);
        for (int k = 0; k < 32; k++) begin
            step(1'b1, 2'b10, 4'd0, 4'd0);
            chk(name, 64'(seg), 64'(segs[7*m_idx +: 7]));
        end
    endtask

    initial begin
        tbl[0] = '{32'h00000123, {B, B, B, B, B, 7'b1111001, 7'b0100100, 7'b0110000}};
        tbl[1] = '{32'h00000000, {B, B, B, B, B, B, B, 7'b1000000}};
        tbl[2] = '{32'h1000000F, {7'b1111001, 7'b1000000, 7'b1000000, 7'b1000000,
                                  7'b1000000, 7'b1000000, 7'b1000000, DS}};
        tbl[3] = '{32'h98765432, {7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010,
                                  7'b0010010, 7'b0011001, 7'b0110000, 7'b0100100}};
        tbl[4] = '{32'h00A00050, {B, B, DS, 7'b1000000, 7'b1000000, 7'b1000000,
                                  7'b0010010, 7'b1000000}};

        reset = 1'b0; status = 2'b10; data = 0; pos = 0;
        do_reset();
        chk("reset an", 64'(an), 64'(8'hFE));
        chk("reset seg", 64'(seg), 64'(B));
        chk("reset frame_valid", 64'(frame_valid), 64'd0);
        chk("reset err", 64'(err), 64'd0);

        // Scan wrap: slot 1 after 4 cycles, back to slot 0 after 32.
        for (int k = 1; k <= 32; k++) begin
            step(1'b1, 2'b10, 4'd0, 4'd0);
            if (k == 4) chk("wrap an@4", 64'(an), 64'(8'hFD));
        end
        chk("wrap an@32", 64'(an), 64'(8'hFE));

        do_reset();
        foreach (tbl[n]) begin
            load(tbl[n].digits);
            step(1'b1, 2'b10, 4'd0, 4'd0);
            chk("commit frame_valid", 64'(frame_valid), 64'd1);
            scan_check("table seg", tbl[n].segs);
        end

        // pos 8 must be ignored, value 12 shows a dash.
        load(32'h00000123);
        step(1'b1, 2'b01, 4'd5, 4'd8);
        step(1'b1, 2'b01, 4'd12, 4'd4);
        step(1'b1, 2'b10, 4'd0, 4'd0);
        step(1'b1, 2'b10, 4'd0, 4'd0);
        scan_check("pos8/dash seg", {B, B, B, DS, 7'b1000000, 7'b1111001,
                                     7'b0100100, 7'b0110000});

        // Empty busy burst still commits the unchanged shadow.
        step(1'b1, 2'b01, 4'd0, 4'd9);
        step(1'b1, 2'b10, 4'd0, 4'd0);
        scan_check("empty commit seg", {B, B, B, DS, 7'b1000000, 7'b1111001,
                                        7'b0100100, 7'b0110000});

        // Busy -> error -> ready: error wins, display locks on Erro.
        step(1'b1, 2'b01, 4'd7, 4'd0);
        step(1'b1, 2'b00, 4'd0, 4'd0);
        step(1'b1, 2'b10, 4'd0, 4'd0);
        chk("err set", 64'(err), 64'd1);
        scan_check("erro seg", {B, B, B, B, 7'b0000110, 7'b0101111,
                                7'b0101111, 7'b0100011});
        load(32'h87654321);
        step(1'b1, 2'b10, 4'd0, 4'd0);
        scan_check("erro after commit", {B, B, B, B, 7'b0000110, 7'b0101111,
                                         7'b0101111, 7'b0100011});
        chk("err sticky", 64'(err), 64'd1);

        // Reset mid-frame discards the capture and blocks the commit.
        do_reset();
        step(1'b1, 2'b01, 4'd9, 4'd0);
        step(1'b0, 2'b01, 4'd0, 4'd0);
        step(1'b1, 2'b10, 4'd0, 4'd0);
        step(1'b1, 2'b10, 4'd0, 4'd0);
        chk("midreset frame_valid", 64'(frame_valid), 64'd0);
        chk("midreset seg", 64'(seg), 64'(B));

        // Random stream against the reference.
        for (int k = 0; k < 1500; k++) begin
            logic       r;
            logic [1:0] s;
            int         w;
            r = ($urandom_range(0, 199) != 0);
            w = $urandom_range(0, 99);
            s = (w < 55) ? 2'b01 : (w < 90) ? 2'b10 : (w < 99) ? 2'b11 : 2'b00;
            step(r, s, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 9)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
